mul_io_sequencer: RTL and testbench

MUL_IO_SEQUENCER -- requirements
Module: mul_io_sequencer

---
 rtl/mul_io_if.sv | 34 +++
 rtl/mul_io_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_mul_io_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_io_if.sv
// mul_io_if: operand-in / product-out handshake bundle for mul_io_sequencer.
//
// Both channels use the same valid/ready rule. The sender raises valid with
// stable data and keeps both unchanged until it sees ready. A transfer
// happens on every rising clk edge where valid && ready. Ready may depend
// on the receiver's state but never on valid in the same cycle.
//
// Signals:
//   in_valid / in_ready / in_multiplicand / in_multiplier : operand pair channel
//   out_valid / out_ready / out_product                    : product channel
// Modports:
//   master : producer of operands and consumer of products (the environment)
//   slave  : the sequencer
interface mul_io_if #(
  parameter int WIDTH_M = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH_M-1:0]     in_multiplicand;
  logic [WIDTH_M-1:0]     in_multiplier;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH_M-1:0]   out_product;

  modport master (
    output in_valid, in_multiplicand, in_multiplier, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_multiplicand, in_multiplier, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/mul_io_sequencer.sv
// mul_io_sequencer: queues operand pairs, launches them one at a time into
// an external multiplier core, waits for the core's completion pulse with a
// timeout, and presents each product on a valid/ready output.
//
// Ports:
//   clk             : sole clock, rising edge
//   reset_n         : asynchronous active-low reset
//   io              : mul_io_if.slave (operand in channel, product out channel)
//   start           : one-cycle launch pulse to the core (high in LAUNCH)
//   op_multiplicand : operand A held for the core from LAUNCH until IDLE
//   op_multiplier   : operand B held for the core from LAUNCH until IDLE
//   core_done       : one-cycle completion pulse from the core
//   core_product    : core result, sampled only with core_done in WAIT
//   busy            : high in every state except IDLE
//   timeout_err     : sticky, set when the core misses its deadline
//   dbg_state       : current FSM state (IDLE=0, LAUNCH=1, WAIT=2, HOLD=3)
module mul_io_sequencer #(
  parameter int WIDTH_M    = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 100
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mul_io_if.slave              io,
  output logic                 start,
  output logic [WIDTH_M-1:0]   op_multiplicand,
  output logic [WIDTH_M-1:0]   op_multiplier,
  input  logic                 core_done,
  input  logic [2*WIDTH_M-1:0] core_product,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [1:0]           dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W = 2 * WIDTH_M;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------
  // Operand FIFO. Entries are {multiplicand, multiplier}. Depth is a power
  // of two, so the pointers wrap naturally by overflowing.
  // ---------------------------------------------------------------------
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  // in_ready only reflects fullness, so a pop in the same cycle never
  // makes room for a push into a full queue.
  assign push  = io.in_valid && !full;
  assign pop   = (state == S_IDLE) && !empty;
  assign head  = mem[rd_ptr];

  assign io.in_ready = !full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {io.in_multiplicand, io.in_multiplier};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]   wait_cnt;
  logic               out_valid_q;
  logic [ENT_W-1:0]   product_q;
  logic               capture;
  logic               expire;
  logic               handshake;

  // core_done wins over the timeout when both land in the last WAIT cycle.
  // The last WAIT cycle is the one in which the counter would reach
  // TIMEOUT, so the core gets exactly TIMEOUT cycles after start.
  assign capture   = (state == S_WAIT) && core_done;
  assign expire    = (state == S_WAIT) && !core_done &&
                     (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign handshake = (state == S_HOLD) && out_valid_q && io.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        start      = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (capture) begin
          state_next = S_HOLD;
        end else if (expire) begin
          state_next = S_IDLE;
        end
      end
      S_HOLD: begin
        if (handshake) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers. Operands load only on pop, so they stay put from
  // LAUNCH through WAIT and HOLD until the next operation is popped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_multiplicand <= '0;
      op_multiplier   <= '0;
      wait_cnt        <= '0;
      out_valid_q     <= 1'b0;
      product_q       <= '0;
      timeout_err     <= 1'b0;
    end else begin
      if (pop) begin
        op_multiplicand <= head[ENT_W-1:WIDTH_M];
        op_multiplier   <= head[WIDTH_M-1:0];
      end

      if (state == S_LAUNCH) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        // Leaves WAIT no later than the cycle it reaches TIMEOUT, so the
        // counter never wraps.
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      if (capture) begin
        product_q   <= core_product;
        out_valid_q <= 1'b1;
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end

      if (expire) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign io.out_valid   = out_valid_q;
  assign io.out_product = product_q;
  assign busy           = (state != S_IDLE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_mul_io_sequencer.sv
// tb_mul_io_sequencer: directed checks of mul_io_sequencer with a small
// behavioural core that answers start pulses after a programmable delay,
// plus a manual core_done path for stray and boundary pulses.
module tb_mul_io_sequencer;
  localparam int W  = 16;
  localparam int D  = 2;
  localparam int TO = 30;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           core_done;
  logic [2*W-1:0] core_product;
  logic           busy;
  logic           timeout_err;
  logic [1:0]     dbg_state;

  logic           core_done_r;
  logic [2*W-1:0] core_product_r;
  logic           man_done;
  logic [2*W-1:0] man_prod;
  logic           auto_core;
  int             core_delay;

  int total;
  int bad;

  logic [2*W-1:0] exp_q[$];

  mul_io_if #(.WIDTH_M(W)) bus ();

  assign core_done    = core_done_r | man_done;
  assign core_product = core_done_r ? core_product_r : man_prod;

  mul_io_sequencer #(
    .WIDTH_M(W), .FIFO_DEPTH(D), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .io(bus),
    .start(start),
    .op_multiplicand(op_a),
    .op_multiplier(op_b),
    .core_done(core_done),
    .core_product(core_product),
    .busy(busy),
    .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural multiplier core
  initial begin
    core_done_r    = 1'b0;
    core_product_r = '0;
    forever begin
      @(negedge clk);
      if (auto_core && start) begin
        repeat (core_delay) @(negedge clk);
        core_product_r = {16'd0, op_a} * {16'd0, op_b};
        core_done_r    = 1'b1;
        @(negedge clk);
        core_done_r    = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // driver tasks (all called and returning on a falling edge)
  // ---------------------------------------------------------------------
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 1'b0;
    bus.in_valid        = 1'b1;
    bus.in_multiplicand = a;
    bus.in_multiplier   = b;
    for (int i = 0; i < 300; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL push_accept: in_ready stayed 0, want 1 within 300 cycles (a=%0d b=%0d)", a, b);
    end
  endtask

  task automatic wait_start(output int cyc);
    cyc = -1;
    for (int i = 0; i < 300; i++) begin
      if (start) begin
        cyc = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume(input logic [2*W-1:0] exp, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_valid: out_valid got 0 want 1 within 400 cycles", name);
    end else begin
      total++;
      if (bus.out_product !== exp) begin
        bad++;
        $display("FAIL %s_product: got %0h want %0h", name, bus.out_product, exp);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s_clear: out_valid got %0b want 0 after handshake", name, bus.out_valid);
      end
    end
  endtask

  // ---------------------------------------------------------------------
  // scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    reset_n             = 1'b0;
    bus.in_valid        = 1'b0;
    bus.in_multiplicand = '0;
    bus.in_multiplier   = '0;
    bus.out_ready       = 1'b0;
    man_done            = 1'b0;
    man_prod            = '0;
    auto_core           = 1'b0;
    core_delay          = 3;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    total++; if (start !== 1'b0) begin bad++; $display("FAIL reset_start: got %0b want 0", start); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err: got %0b want 0", timeout_err); end
    total++; if (bus.out_product !== 32'd0) begin bad++; $display("FAIL reset_out_product: got %0h want 0", bus.out_product); end
    total++; if ({op_a, op_b} !== 32'd0) begin bad++; $display("FAIL reset_ops: got %0h want 0", {op_a, op_b}); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_release: start=%0b busy=%0b want 0 0", start, busy); end
  endtask

  task automatic test_single();
    int cyc;
    auto_core = 1'b0;
    push(16'd3, 16'd5);
    wait_start(cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL single_pop_to_start: got %0d want 1 cycles", cyc); end
    total++; if (op_a !== 16'd3 || op_b !== 16'd5) begin bad++; $display("FAIL single_ops: got %0d,%0d want 3,5", op_a, op_b); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %0b want 1", busy); end
    @(negedge clk);
    total++; if (start !== 1'b0) begin bad++; $display("FAIL single_start_width: got %0b want 0", start); end
    repeat (19) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %0b want 0", bus.out_valid); end
    man_prod = 32'd15;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_done_to_valid: got %0b want 1", bus.out_valid); end
    total++; if (bus.out_product !== 32'd15) begin bad++; $display("FAIL single_product: got %0d want 15", bus.out_product); end
    repeat (3) @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_product !== 32'd15) begin bad++; $display("FAIL single_hold: valid=%0b prod=%0d want 1 15", bus.out_valid, bus.out_product); end
    total++; if (op_a !== 16'd3 || op_b !== 16'd5) begin bad++; $display("FAIL single_ops_stable: got %0d,%0d want 3,5", op_a, op_b); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_clear: got %0b want 0", bus.out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy got %0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    bit ok = 1'b0;
    auto_core  = 1'b1;
    core_delay = 3;
    push(16'd2, 16'd7);
    push(16'd4, 16'd4);
    push(16'd9, 16'd9);
    // a fourth pair must stall while the queue is full and the first result waits
    bus.in_valid        = 1'b1;
    bus.in_multiplicand = 16'd6;
    bus.in_multiplier   = 16'd5;
    repeat (8) @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall: in_ready got %0b want 0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b1 || bus.out_product !== 32'd14) begin bad++; $display("FAIL b2b_held: valid=%0b prod=%0d want 1 14", bus.out_valid, bus.out_product); end
    consume(32'd14, "b2b_first");
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    bus.in_valid = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL b2b_resume: in_ready got 0 want 1 after consume"); end
    consume(32'd16, "b2b_second");
    consume(32'd81, "b2b_third");
    consume(32'd30, "b2b_fourth");
  endtask

  task automatic test_stray_done();
    bit seen = 1'b0;
    auto_core  = 1'b1;
    core_delay = 5;
    push(16'd10, 16'd10);
    for (int i = 0; i < 100; i++) begin
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!seen) begin bad++; $display("FAIL stray_setup: out_valid got 0 want 1"); end
    man_prod = 32'hDEAD_BEEF;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    total++; if (bus.out_product !== 32'd100) begin bad++; $display("FAIL stray_hold_product: got %0h want 64", bus.out_product); end
    total++; if (dbg_state !== 2'd3 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL stray_hold_state: state=%0d valid=%0b want 3 1", dbg_state, bus.out_valid); end
    consume(32'd100, "stray");
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    total++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL stray_idle_state: busy=%0b valid=%0b want 0 0", busy, bus.out_valid); end
    total++; if (bus.out_product !== 32'd100) begin bad++; $display("FAIL stray_idle_product: got %0h want 64", bus.out_product); end
  endtask

  task automatic test_done_at_limit();
    int cyc;
    auto_core = 1'b0;
    push(16'd7, 16'd8);
    wait_start(cyc);
    total++; if (cyc < 0) begin bad++; $display("FAIL limit_start: no start within 300 cycles"); end
    repeat (TO) @(negedge clk);
    man_prod = 32'd56;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_product !== 32'd56) begin bad++; $display("FAIL limit_capture: valid=%0b prod=%0d want 1 56", bus.out_valid, bus.out_product); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL limit_no_err: timeout_err got %0b want 0", timeout_err); end
    consume(32'd56, "limit");
  endtask

  task automatic test_timeout();
    int cyc;
    auto_core = 1'b0;
    push(16'd1, 16'd1);
    push(16'd5, 16'd6);
    wait_start(cyc);
    total++; if (cyc < 0) begin bad++; $display("FAIL timeout_start: no start within 300 cycles"); end
    repeat (TO) @(negedge clk);
    total++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL timeout_early: err=%0b busy=%0b want 0 1", timeout_err, busy); end
    @(negedge clk);
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err_set: got %0b want 1", timeout_err); end
    total++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL timeout_discard: valid=%0b busy=%0b want 0 0", bus.out_valid, busy); end
    auto_core  = 1'b1;
    core_delay = 4;
    consume(32'd30, "timeout_next");
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %0b want 1", timeout_err); end
  endtask

  task automatic test_wrap();
    auto_core  = 1'b1;
    core_delay = 2;
    exp_q = {32'd2, 32'd12, 32'd30, 32'd56, 32'h0000_FE01, 32'hFFFE_0001};
    fork
      begin
        push(16'd1, 16'd2);
        push(16'd3, 16'd4);
        push(16'd5, 16'd6);
        push(16'd7, 16'd8);
        push(16'd255, 16'd255);
        push(16'hFFFF, 16'hFFFF);
      end
      begin
        for (int k = 0; k < 6; k++) begin
          consume(exp_q.pop_front(), "wrap");
        end
      end
    join
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL wrap_err_sticky: got %0b want 1", timeout_err); end
  endtask

  task automatic test_reset_in_wait();
    int cyc;
    bit saw_start = 1'b0;
    bit saw_busy  = 1'b0;
    auto_core = 1'b0;
    push(16'd3, 16'd3);
    push(16'd4, 16'd4);
    wait_start(cyc);
    repeat (3) @(negedge clk);
    total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL rst_wait_setup: state got %0d want 2", dbg_state); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL rst_wait_state: busy=%0b state=%0d want 0 0", busy, dbg_state); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_wait_err: got %0b want 0", timeout_err); end
    total++; if ({op_a, op_b} !== 32'd0 || bus.out_product !== 32'd0) begin bad++; $display("FAIL rst_wait_data: ops=%0h prod=%0h want 0 0", {op_a, op_b}, bus.out_product); end
    total++; if (bus.in_ready !== 1'b1 || start !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_flags: in_ready=%0b start=%0b valid=%0b want 1 0 0", bus.in_ready, start, bus.out_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (start) saw_start = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    total++; if (saw_start || saw_busy) begin bad++; $display("FAIL rst_wait_release: start_seen=%0b busy_seen=%0b want 0 0", saw_start, saw_busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stray_done();
    test_done_at_limit();
    test_timeout();
    test_wrap();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
